// File: rtl/div4b_seq.sv
// rtl/div4b_seq.sv - sequential 4-bit unsigned restoring divider driving an external adder/subtractor
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   division request, sampled only while busy=0
//   dividend     in   unsigned dividend, captured with start
//   divisor      in   unsigned divisor, captured with start
//   busy         out  high from the accepting edge until back in IDLE
//   done         out  one-cycle completion pulse
//   quotient     out  registered quotient, held until the next completion
//   remainder    out  registered remainder, held until the next completion
//   div_by_zero  out  registered flag, set when the captured divisor was 0
//   sub_a        out  subtractor operand A
//   sub_b        out  subtractor operand B
//   sub_sel      out  subtractor mode (1 = subtract)
//   sub_rest     in   subtractor result
//   sub_cout     in   subtractor carry out (1 = no borrow, A >= B)

module div4b_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_sel,
    input  logic [WIDTH-1:0] sub_rest,
    input  logic             sub_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;      // partial remainder
    logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;      // captured divisor
    logic [1:0]       cnt_q;    // iteration counter, last iteration at 3
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH-1:0] shifted;
    logic             acc;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic [1:0]       cnt_d;

    // One restoring step: shift the next dividend bit into the remainder,
    // keep the difference only when the subtractor reports no borrow.
    // R[3] is always 0 in RUN (R < D or R <= 7), so dropping it loses nothing.
    always_comb begin
        shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        acc     = sub_cout;
        r_d     = acc ? sub_rest : shifted;
        q_d     = {q_q[WIDTH-2:0], acc};
        cnt_d   = cnt_q + 2'd1;
    end

    // The subtractor is only exercised in RUN; elsewhere it sees a quiet zero add.
    always_comb begin
        sub_a   = '0;
        sub_b   = '0;
        sub_sel = 1'b0;
        if (state_q == S_RUN) begin
            sub_a   = shifted;
            sub_b   = d_q;
            sub_sel = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        r_q     <= '0;
                        q_q     <= dividend;
                        d_q     <= divisor;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == 2'd3) begin
                        // Results come straight from the last step's next-state values.
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        dbz_q   <= (d_q == '0);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here; busy stays high for this cycle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div4b_seq.sv
// tb/tb_div4b_seq.sv - self-checking bench for div4b_seq with a behavioural subtractor

module tb_div4b_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic [3:0] sub_a;
    logic [3:0] sub_b;
    logic       sub_sel;
    logic [3:0] sub_rest;
    logic       sub_cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    div4b_seq #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_sel     (sub_sel),
        .sub_rest    (sub_rest),
        .sub_cout    (sub_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational 4-bit adder/subtractor sitting next to the divider at the parent level.
    logic [4:0] add_sum;
    assign add_sum  = {1'b0, sub_a} + {1'b0, sub_b};
    assign sub_rest = sub_sel ? (sub_a - sub_b) : add_sum[3:0];
    assign sub_cout = sub_sel ? (sub_a >= sub_b) : add_sum[4];

    function automatic logic [3:0] ref_quot(input logic [3:0] a, input logic [3:0] b);
        return (b == 4'd0) ? 4'hF : 4'(a / b);
    endfunction

    function automatic logic [3:0] ref_rem(input logic [3:0] a, input logic [3:0] b);
        return (b == 4'd0) ? a : 4'(a % b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full division with latency, interface and result checks; operands are scrambled after E0.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            chk("run_busy", busy, 1);
            chk("run_sub_sel", sub_sel, 1);
            chk("run_sub_b", sub_b, b);
            chk("run_r3_zero", dut.r_q[3], 0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 5);
        chk("done_pulse", done, 1);
        chk("quotient", quotient, ref_quot(a, b));
        chk("remainder", remainder, ref_rem(a, b));
        chk("div_by_zero", div_by_zero, (b == 4'd0));
        chk("done_busy", busy, 1);
        chk("done_sub_a", sub_a, 0);
        chk("done_sub_b", sub_b, 0);
        chk("done_sub_sel", sub_sel, 0);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sub_sel", sub_sel, 0);
        chk("idle_quot_hold", quotient, ref_quot(a, b));
    endtask

    initial begin
        int n;
        int stamps[$];
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_sub_a", sub_a, 0);
        chk("rst_sub_sel", sub_sel, 0);
        rst = 1'b0;

        // Directed cases including divide by zero.
        run_div(4'd13, 4'd3);
        run_div(4'd15, 4'd1);
        run_div(4'd7,  4'd9);
        run_div(4'd15, 4'd15);
        run_div(4'd9,  4'd0);

        // Starts during RUN and DONE are ignored.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("ign_done_seen", done, 1);
        chk("ign_run_quot", quotient, 4);
        chk("ign_run_rem", remainder, 1);
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        chk("ign_idle_busy", busy, 0);
        @(negedge clk);
        chk("ign_not_accepted", busy, 0);
        chk("ign_quot_hold", quotient, 4);
        chk("ign_rem_hold", remainder, 1);

        // Continuous start: one result every 6 cycles.
        @(negedge clk);
        start = 1'b1; dividend = 4'd11; divisor = 4'd2;
        for (int i = 0; i < 30 && stamps.size() < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                stamps.push_back(cyc);
                chk("b2b_quot", quotient, 5);
                chk("b2b_rem", remainder, 1);
            end
        end
        start = 1'b0;
        chk("b2b_count", stamps.size(), 3);
        if (stamps.size() == 3) begin
            chk("b2b_gap1", stamps[1] - stamps[0], 6);
            chk("b2b_gap2", stamps[2] - stamps[1], 6);
        end
        repeat (6) @(negedge clk);

        // Randomized operands against the reference model.
        for (int i = 0; i < 30; i++)
            run_div(4'($urandom), 4'($urandom_range(15, 0)));

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_div(4'(a), 4'(b));

        // Reset after E2 aborts the division asynchronously.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quot", quotient, 0);
        chk("arst_rem", remainder, 0);
        chk("arst_dbz", div_by_zero, 0);
        chk("arst_sub_sel", sub_sel, 0);
        chk("arst_sub_b", sub_b, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) n++;
        end
        chk("arst_no_done", n, 0);
        chk("arst_idle_quot", quotient, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
